// File: rtl/sample_buffer_pkg.sv
// ============================================================================
// sample_buffer_pkg : shared FSM encoding and default sizing for sample_buffer
// Revision: 1.0
// ============================================================================
`default_nettype none

package sample_buffer_pkg;

  localparam int C_DEFAULT_DEPTH       = 16;
  localparam int C_DEFAULT_CAPTURE_LEN = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  // Only masked channels take part in the trigger compare.
  function automatic logic trig_hit(
    input logic [7:0] probe,
    input logic [7:0] mask,
    input logic [7:0] value
  );
    return (probe & mask) == (value & mask);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// sync_fifo : single-clock FIFO with flush, fall-through read data and
//             next-cycle occupancy output
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_wr_data,
  output logic [WIDTH-1:0]       o_rd_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count_next
);

  localparam int          AW     = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          push_ok;
  logic          pop_ok;

  assign o_full  = (count_q == C_FULL);
  assign o_empty = (count_q == '0);

  // A pop frees the head slot this cycle, so a push at full still lands.
  assign pop_ok  = i_pop & ~o_empty;
  assign push_ok = i_push & (~o_full | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok) begin
        count_d = count_q + 1'b1;
      end else if (!push_ok && pop_ok) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !i_flush) begin
      mem[wr_ptr_q] <= i_wr_data;
    end
  end

  assign o_rd_data    = mem[rd_ptr_q];
  assign o_count_next = count_d;

endmodule

`default_nettype wire

// File: rtl/sample_buffer.sv
// ============================================================================
// sample_buffer : triggered logic-analyzer capture into a FIFO drained by a
//                 UART through an RdCLK rising-edge handshake
// Revision: 1.0
// ============================================================================
`default_nettype none

module sample_buffer
  import sample_buffer_pkg::*;
#(
  parameter int DEPTH       = C_DEFAULT_DEPTH,
  parameter int CAPTURE_LEN = C_DEFAULT_CAPTURE_LEN
) (
  input  logic       CLK,
  input  logic       Init,
  input  logic [7:0] Probe,
  input  logic       Sample,
  input  logic       Arm,
  input  logic [7:0] TrigMask,
  input  logic [7:0] TrigValue,
  input  logic       RdCLK,
  output logic [7:0] Data,
  output logic       EN,
  output logic       Busy,
  output logic       Overflow
);

  localparam int            CW    = $clog2(CAPTURE_LEN + 1);
  localparam logic [CW-1:0] C_LEN = CW'(CAPTURE_LEN);

  state_t               state_q, state_d;
  logic [CW-1:0]        samp_cnt_q, samp_cnt_d;
  logic                 rd_prev_q;
  logic                 en_q, en_d;
  logic                 busy_q, busy_d;
  logic                 overflow_q, overflow_d;

  logic                 push;
  logic                 pop;
  logic                 flush;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [7:0]           fifo_rd_data;
  logic [$clog2(DEPTH):0] fifo_count_next;

  // Only a low-to-high RdCLK transition consumes a byte.
  assign pop = RdCLK & ~rd_prev_q & ~fifo_empty;

  always_comb begin
    state_d    = state_q;
    samp_cnt_d = samp_cnt_q;
    overflow_d = overflow_q;
    push       = 1'b0;
    flush      = 1'b0;
    case (state_q)
      IDLE: begin
        if (Arm) begin
          state_d    = ARMED;
          flush      = 1'b1;
          overflow_d = 1'b0;
          samp_cnt_d = '0;
        end
      end
      ARMED: begin
        if (Sample && trig_hit(Probe, TrigMask, TrigValue)) begin
          push       = 1'b1;
          samp_cnt_d = CW'(1);
          state_d    = (CAPTURE_LEN == 1) ? DRAIN : CAPTURE;
        end
      end
      CAPTURE: begin
        if (Sample) begin
          push       = 1'b1;
          samp_cnt_d = samp_cnt_q + CW'(1);
          if (samp_cnt_d == C_LEN) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // The sample still counts toward the capture length when it is dropped.
    if (push && fifo_full && !pop) overflow_d = 1'b1;
  end

  assign en_d   = (fifo_count_next != '0);
  assign busy_d = (state_d != IDLE);

  always_ff @(posedge CLK or posedge Init) begin
    if (Init) begin
      state_q    <= IDLE;
      samp_cnt_q <= '0;
      rd_prev_q  <= 1'b0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      samp_cnt_q <= samp_cnt_d;
      rd_prev_q  <= RdCLK;
      en_q       <= en_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk          (CLK),
    .rst          (Init),
    .i_flush      (flush),
    .i_push       (push),
    .i_pop        (pop),
    .i_wr_data    (Probe),
    .o_rd_data    (fifo_rd_data),
    .o_full       (fifo_full),
    .o_empty      (fifo_empty),
    .o_count_next (fifo_count_next)
  );

  assign Data     = fifo_rd_data;
  assign EN       = en_q;
  assign Busy     = busy_q;
  assign Overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_sample_buffer.sv
// ============================================================================
// tb_sample_buffer : directed bench for sample_buffer with a queue-based model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sample_buffer;

  localparam int DEPTH = 4;
  localparam int LEN   = 6;

  localparam int M_IDLE    = 0;
  localparam int M_ARMED   = 1;
  localparam int M_CAPTURE = 2;
  localparam int M_DRAIN   = 3;

  logic       clk = 1'b0;
  logic       Init;
  logic [7:0] Probe;
  logic       Sample;
  logic       Arm;
  logic [7:0] TrigMask;
  logic [7:0] TrigValue;
  logic       RdCLK;
  logic [7:0] Data;
  logic       EN;
  logic       Busy;
  logic       Overflow;

  sample_buffer #(
    .DEPTH       (DEPTH),
    .CAPTURE_LEN (LEN)
  ) dut (
    .CLK       (clk),
    .Init      (Init),
    .Probe     (Probe),
    .Sample    (Sample),
    .Arm       (Arm),
    .TrigMask  (TrigMask),
    .TrigValue (TrigValue),
    .RdCLK     (RdCLK),
    .Data      (Data),
    .EN        (EN),
    .Busy      (Busy),
    .Overflow  (Overflow)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         m_state;
  int         m_cnt;
  bit         m_ovf;
  bit         m_prev;
  logic [7:0] mq [$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE;
    m_cnt   = 0;
    m_ovf   = 1'b0;
    m_prev  = 1'b0;
    mq.delete();
  endtask

  // One clock of behaviour, from the inputs presented before the edge.
  task automatic model_step();
    int sz;
    bit do_pop;
    bit do_push;
    sz      = mq.size();
    do_pop  = RdCLK && !m_prev && (sz != 0);
    m_prev  = RdCLK;
    do_push = 1'b0;
    if (m_state == M_ARMED && Sample && (((Probe ^ TrigValue) & TrigMask) == 8'h00))
      do_push = 1'b1;
    if (m_state == M_CAPTURE && Sample)
      do_push = 1'b1;
    if (m_state == M_IDLE && Arm) begin
      mq.delete();
      m_ovf   = 1'b0;
      m_cnt   = 0;
      m_state = M_ARMED;
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        if (sz < DEPTH || do_pop) mq.push_back(Probe);
        else m_ovf = 1'b1;
        m_cnt = m_cnt + 1;
        m_state = (m_cnt >= LEN) ? M_DRAIN : M_CAPTURE;
      end else if (m_state == M_DRAIN && sz == 0) begin
        m_state = M_IDLE;
      end
    end
  endtask

  task automatic compare();
    chk("EN", {7'd0, EN}, {7'd0, mq.size() != 0});
    chk("Busy", {7'd0, Busy}, {7'd0, m_state != M_IDLE});
    chk("Overflow", {7'd0, Overflow}, {7'd0, m_ovf});
    if (mq.size() != 0) chk("Data", Data, mq[0]);
  endtask

  task automatic tick();
    @(posedge clk);
    if (Init) model_reset();
    else model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic cyc(input bit a, input bit s, input logic [7:0] p, input bit r);
    Arm    = a;
    Sample = s;
    Probe  = p;
    RdCLK  = r;
    tick();
  endtask

  initial begin
    Init      = 1'b1;
    Arm       = 1'b0;
    Sample    = 1'b0;
    Probe     = 8'h00;
    RdCLK     = 1'b0;
    TrigMask  = 8'h0F;
    TrigValue = 8'h05;
    model_reset();

    tick();
    tick();
    chk("rst_EN", {7'd0, EN}, 8'h00);
    chk("rst_Busy", {7'd0, Busy}, 8'h00);
    chk("rst_Overflow", {7'd0, Overflow}, 8'h00);

    // Masked trigger, push/pop interplay and push+pop at full.
    Init = 1'b0;
    cyc(1, 0, 8'h00, 0);  chk("arm_Busy", {7'd0, Busy}, 8'h01);
    cyc(0, 1, 8'h13, 0);  chk("miss_EN", {7'd0, EN}, 8'h00);
    cyc(0, 1, 8'hA5, 0);  chk("trig_EN", {7'd0, EN}, 8'h01);
                          chk("trig_Data", Data, 8'hA5);
    cyc(0, 1, 8'h01, 0);  chk("hold_Data", Data, 8'hA5);
    cyc(0, 1, 8'h22, 1);  chk("pp_Data", Data, 8'h01);
    cyc(0, 1, 8'h33, 0);
    cyc(0, 1, 8'h44, 0);
    cyc(0, 1, 8'h77, 1);  chk("full_pp_Data", Data, 8'h22);
                          chk("full_pp_Ovf", {7'd0, Overflow}, 8'h00);
                          chk("full_pp_EN", {7'd0, EN}, 8'h01);
    cyc(0, 0, 8'h00, 1);
    cyc(0, 0, 8'h00, 1);  chk("level_Data", Data, 8'h22);
    cyc(0, 0, 8'h00, 0);
    cyc(0, 0, 8'h00, 1);  chk("edge_Data", Data, 8'h33);
    cyc(0, 0, 8'h00, 1);
    cyc(0, 0, 8'h00, 1);  chk("held3_Data", Data, 8'h33);
    cyc(0, 0, 8'h00, 0);
    cyc(0, 0, 8'h00, 1);  chk("pop3_Data", Data, 8'h44);
    cyc(0, 0, 8'h00, 0);
    cyc(0, 0, 8'h00, 1);  chk("pop4_Data", Data, 8'h77);
    cyc(0, 0, 8'h00, 0);
    cyc(0, 0, 8'h00, 1);  chk("last_EN", {7'd0, EN}, 8'h00);
                          chk("last_Busy", {7'd0, Busy}, 8'h01);
    cyc(0, 0, 8'h00, 0);  chk("idle_Busy", {7'd0, Busy}, 8'h00);

    // Unmasked trigger, empty pop, overflow, drain, re-arm.
    TrigMask = 8'h00;
    cyc(1, 0, 8'h00, 0);
    cyc(0, 0, 8'h00, 1);
    cyc(0, 0, 8'h00, 0);
    cyc(0, 1, 8'h10, 0);  chk("mask0_Data", Data, 8'h10);
    cyc(0, 1, 8'h11, 0);
    cyc(0, 1, 8'h12, 0);
    cyc(0, 1, 8'h13, 0);
    cyc(0, 1, 8'h14, 0);  chk("drop_Ovf", {7'd0, Overflow}, 8'h01);
    cyc(0, 1, 8'h15, 0);  chk("drop_Data", Data, 8'h10);
    cyc(0, 1, 8'h99, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 8'h00, 1);
      if (i < 3) chk("drain_Data", Data, 8'h11 + 8'(i));
      cyc(0, 0, 8'h00, 0);
    end
    chk("drain_EN", {7'd0, EN}, 8'h00);
    chk("drain_Busy", {7'd0, Busy}, 8'h00);
    cyc(1, 0, 8'h00, 0);  chk("rearm_Ovf", {7'd0, Overflow}, 8'h00);

    // Init in the middle of a capture discards buffered bytes.
    cyc(0, 1, 8'h21, 0);
    cyc(0, 1, 8'h22, 0);
    cyc(0, 1, 8'h23, 0);
    Init = 1'b1;
    #1;
    chk("init_EN", {7'd0, EN}, 8'h00);
    chk("init_Busy", {7'd0, Busy}, 8'h00);
    cyc(0, 0, 8'h00, 0);
    Init = 1'b0;
    cyc(1, 0, 8'h00, 0);  chk("post_arm_Busy", {7'd0, Busy}, 8'h01);
    cyc(0, 1, 8'h31, 0);  chk("post_Data", Data, 8'h31);
    cyc(0, 0, 8'h00, 1);  chk("post_pop_EN", {7'd0, EN}, 8'h00);
    cyc(0, 0, 8'h00, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sample_buffer.md
SAMPLE_BUFFER -- requirements
Module: sample_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two).
REQ-002 SHALL have parameter CAPTURE_LEN, default 16, samples stored per trigger (1..DEPTH).
REQ-003 SHALL have port CLK  input  1  single clock; same clock as the downstream UART transmitter's sending clock.
REQ-004 SHALL have port Init  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port Probe  input  8  logic-analyzer channels being captured.
REQ-006 SHALL have port Sample  input  1  one-cycle sample strobe; Probe is valid when Sample=1.
REQ-007 SHALL have port Arm  input  1  one-cycle request to start a new acquisition.
REQ-008 SHALL have port TrigMask  input  8  1 = channel participates in the trigger compare.
REQ-009 SHALL have port TrigValue  input  8  required level per masked channel.
REQ-010 SHALL have port RdCLK  input  1  read-advance level from the UART; its rising edge consumes one byte.
REQ-011 SHALL have port Data  output  8  byte at the FIFO head, presented to the UART.
REQ-012 SHALL have port EN  output  1  1 = FIFO not empty, UART may start a frame.
REQ-013 SHALL have port Busy  output  1  1 = state is not IDLE.
REQ-014 SHALL have port Overflow  output  1  sticky flag: a sample was dropped because the FIFO was full.

Function
REQ-015 SHALL implement the states IDLE, ARMED, CAPTURE and DRAIN, encoded in 2 bits.
REQ-016 IDLE: Arm=1 SHALL go to ARMED next cycle, flush the FIFO (pointers=0) and clear Overflow.
REQ-017 Arm SHALL be ignored in every state other than IDLE.
REQ-018 ARMED: Sample=1 with (Probe & TrigMask)==(TrigValue & TrigMask) SHALL push Probe, set the sample count to 1 and go to CAPTURE.
REQ-019 ARMED: Sample=1 on a trigger miss SHALL push nothing.
REQ-020 TrigMask=0 SHALL trigger on the first Sample.
REQ-021 CAPTURE: each Sample=1 SHALL push Probe and increment the count.
REQ-022 CAPTURE: when the count reaches CAPTURE_LEN (including CAPTURE_LEN=1 at trigger), the state SHALL go to DRAIN the cycle after that push.
REQ-023 DRAIN: the state SHALL go to IDLE in the cycle after the FIFO becomes empty; no pushes occur in DRAIN.
REQ-024 Pop SHALL occur when RdCLK=1, the registered previous RdCLK=0 and the FIFO is not empty.
REQ-025 A pop on an empty FIFO SHALL be ignored, with pointers unchanged.
REQ-026 Draining SHALL be permitted in CAPTURE and DRAIN concurrently with capture.
REQ-027 A push and a pop in the same cycle SHALL both take effect; the occupancy count stays unchanged, and this also holds when the FIFO is full.
REQ-028 A push while full without a simultaneous pop SHALL drop the sample and set Overflow=1; the count still increments.
REQ-029 Pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; the occupancy counter SHALL be log2(DEPTH)+1 bits; full is occupancy==DEPTH, empty is occupancy==0.
REQ-030 Data SHALL equal mem[read pointer] combinationally from registered state.
REQ-031 Data SHALL update in the cycle after a pop and be stable while EN=1 and no pop occurs.
REQ-032 EN SHALL be registered and equal to (occupancy!=0).
REQ-033 EN SHALL rise one cycle after the first push into an empty FIFO and fall one cycle after the last pop.
REQ-034 Busy SHALL be registered and equal to (state!=IDLE).
REQ-035 Memory contents SHALL NOT require reset; Data is don't-care while EN=0.

Reset
REQ-036 Init=1 SHALL asynchronously force state=IDLE, pointers=0, occupancy=0, sample count=0, RdCLK edge register=0, EN=0, Busy=0 and Overflow=0.
REQ-037 Init asserted mid-CAPTURE or mid-DRAIN SHALL discard all buffered data; no partial byte is reissued after release.
REQ-038 After Init release, the block SHALL accept Arm on the first clock edge.

Structure
REQ-039 A shared package SHALL hold the state encoding constants (IDLE=0, ARMED=1, CAPTURE=2, DRAIN=3) and the default DEPTH and CAPTURE_LEN.
REQ-040 The storage SHALL be one sub-module, sync_fifo (push/pop/full/empty/count, parameter DEPTH); the FSM, trigger compare and RdCLK edge detect live in sample_buffer.

Verification
REQ-041 Trigger mask: Arm; TrigMask=8'h0F, TrigValue=8'h05; Samples 8'h13, 8'hA5, 8'h01 -> trigger on 8'hA5; FIFO holds A5, 01; EN=1 one cycle after the A5 push.
REQ-042 Full capture and drain: CAPTURE_LEN=4; Samples 10,11,12,13 after trigger; four RdCLK rising edges -> Data sequence 10,11,12,13; EN=0 after the fourth pop; Busy=0 one cycle later.
REQ-043 Overflow: DEPTH=4, CAPTURE_LEN=6, no RdCLK; six samples -> first four kept, Overflow=1; a new Arm in IDLE -> Overflow=0.
REQ-044 Simultaneous push and pop at full: push 8'h77 with an RdCLK edge at occupancy=4 -> old head popped, 77 stored, occupancy=4, Overflow=0.
REQ-045 RdCLK held high 3 cycles -> exactly one pop; RdCLK edge while EN=0 -> no pointer change.
REQ-046 Init asserted in CAPTURE with occupancy 3 -> same cycle: EN=0, Busy=0; after release, Arm and new samples start from an empty FIFO.
